// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. The bit clock is CLK_FREQ / BAUD_RATE system clocks.
// The start bit is confirmed at its centre, and each data bit and the stop bit are
// sampled one bit period apart. A byte is published only if its stop bit reads high.
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchronizer stages. rx_sync_r is the synchronized line (rx_s).
  // rx_prev_r holds the previous rx_s value, for edge detection.
  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_prev_r;
  state_t        state_r,   state_s;
  logic [CW-1:0] cnt_r,     cnt_s;
  logic [2:0]    bit_cnt_r, bit_cnt_s;
  logic [7:0]    shift_r,   shift_s;
  logic [7:0]    data_r,    data_s;
  logic          valid_r,   valid_s;
  logic          start_edge_s;

  assign data_out = data_r;
  assign valid    = valid_r;

  // A start is a high-to-low step of the synchronized line.
  // A line held low therefore never starts a frame again.
  assign start_edge_s = rx_prev_r & ~rx_sync_r;

  // Two-flop synchronizer plus an edge-detect stage. All three reset high,
  // so leaving reset cannot look like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // State register for the FSM, the bit timer and the datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      data_r    <= data_s;
      valid_r   <= valid_s;
    end
  end

  // Next-state and datapath logic. The bit timer restarts from zero
  // on every state change and after every data-bit sample.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    data_s    = data_r;
    valid_s   = valid_r;
    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        if (start_edge_s) begin
          valid_s   = 1'b0;
          bit_cnt_s = 3'd0;
          state_s   = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s = CNT_ZERO;
          if (!rx_sync_r) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s     = CNT_ZERO;
          shift_s   = {rx_sync_r, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
          if (rx_sync_r) begin
            data_s  = shift_r;
            valid_s = 1'b1;
          end else begin
            data_s  = data_r;
            valid_s = 1'b0;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 8 clocks per bit.
// The stimulus pushes the expected bytes into a queue. The monitor pops one byte
// on each rising edge of valid and compares it with data_out. The monitor also
// checks the start-to-valid latency and the delay before valid clears.
module tb_uart_rx;

  localparam int CLK_FREQ  = 800_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = CPB / 2;
  localparam int LAT       = 2 + HALF + 9 * CPB + 1;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;

  int vectors;
  int miscompares;
  int cyc;
  int fall_cyc;
  logic [7:0] exp_q[$];
  logic valid_prev;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_out(data_out), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: score each newly presented byte and check the valid edge timing.
  initial valid_prev = 1'b0;
  always @(negedge clk) begin
    if (valid === 1'b1 && valid_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", {24'd0, data_out}, 32'hFFFF_FFFF);
      end else begin
        chk("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        chk_range("valid_latency", cyc - fall_cyc, LAT - 1, LAT + 1);
      end
    end else if (valid !== 1'b1 && valid_prev === 1'b1 && reset === 1'b1) begin
      chk_range("valid_clear_delay", cyc - fall_cyc, 2, 4);
    end
    valid_prev = valid;
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame. The call must start 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    fall_cyc = cyc;
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_bit();
    end
    rx = stop;
    wait_bit();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    fall_cyc    = 0;
    rx          = 1'b1;
    reset       = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    chk("reset_data_out", {24'd0, data_out}, 32'h0000_0000);
    chk("reset_valid", {31'd0, valid}, 32'd0);

    // Single byte 0x55. valid must stay high while the line idles.
    align();
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    chk("valid_hold", {31'd0, valid}, 32'd1);
    chk("hold_data_55", {24'd0, data_out}, 32'h0000_0055);

    // Back-to-back image bytes with indices 200..299. These cross the 8-bit wrap.
    align();
    for (int idx = 200; idx < 300; idx++) begin
      int row;
      int col;
      logic [7:0] pix;
      row = idx / 28;
      col = idx % 28;
      pix = 8'((row * 28 + col) % 256);
      exp_q.push_back(pix);
      send_byte(pix, 1'b1);
    end
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    chk("b2b_last_data", {24'd0, data_out}, 32'h0000_002B);

    // A 2-clock low glitch, shorter than half a bit: no byte is produced,
    // valid clears at the edge, and data_out is kept.
    align();
    fall_cyc = cyc;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    chk("glitch_valid", {31'd0, valid}, 32'd0);
    chk("glitch_data", {24'd0, data_out}, 32'h0000_002B);

    // Framing error on 0xA3: the byte is discarded. Then 0x3C is received.
    align();
    send_byte(8'hA3, 1'b0);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    chk("frame_err_valid", {31'd0, valid}, 32'd0);
    chk("frame_err_data", {24'd0, data_out}, 32'h0000_002B);
    align();
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    repeat (CPB) @(posedge clk);
    @(negedge clk);
    chk("after_err_data", {24'd0, data_out}, 32'h0000_003C);

    // Reset during the data bits, then 0xFF: only 0xFF is reported.
    align();
    fall_cyc = cyc;
    rx = 1'b0;
    wait_bit();
    repeat (3) wait_bit();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (CPB) @(posedge clk);
    @(negedge clk);
    chk("midreset_valid", {31'd0, valid}, 32'd0);
    chk("midreset_data", {24'd0, data_out}, 32'h0000_0000);
    align();
    reset = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    chk("post_reset_idle_valid", {31'd0, valid}, 32'd0);
    align();
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1);
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    chk("final_data_ff", {24'd0, data_out}, 32'h0000_00FF);
    chk("final_valid", {31'd0, valid}, 32'd1);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
